watch_set_ctrl: RTL
===================

Name: watch_set_ctrl

Overview:
Sequencing controller for the loadable mm:ss watch datapath: the cur_time and set_time loadable_counter_dec_60 pairs.
- Decodes button edge pulses into a set-mode FSM.
- Issues the capture and commit load strobes to the counters.
- Steers increment pulses to the selected field.
- Generates a digit-blink mask for the FND driver.
- Replaces the bare toggle-flop plus edge-detector mode logic with explicit edit, commit and cancel semantics.

Parameters:
BLINK_MS, 500, clk_msec ticks per blink half-period (blink phase toggles every BLINK_MS ticks)
TIMEOUT_SEC, 30, clk_sec ticks of button inactivity before an edit aborts (used only with the optional feature)

Ports:
clk  input  1  system clock
reset_p  input  1  asynchronous active-high reset
btn_pedge  input  4  single-cycle button pulses: [0] enter/commit, [1] field select, [2] increment, [3] cancel
clk_msec  input  1  1 ms single-cycle tick from clock_set
clk_sec  input  1  1 s single-cycle tick from clock_set
set_mode  output  1  high while the display/edge mux shows set_time
set_load_en  output  1  1-cycle strobe: load set_time counters from cur_time
cur_load_en  output  1  1-cycle strobe: load cur_time counters from set_time
inc_sec  output  1  1-cycle increment pulse to set_time seconds counter
inc_min  output  1  1-cycle increment pulse to set_time minutes counter
blink_mask  output  4  per-digit blank enable {min10,min1,sec10,sec1}; 1 = blank digit
timeout_pulse  output  1  1-cycle strobe on edit abort by timeout

Behaviour:
- Interface: one clock clk; reset_p is asynchronous and active-high.
- Reset values: FSM in RUN; every output 0; blink phase 0; timeout counter 0.
- All outputs are registered. A response appears in the cycle after the btn_pedge sample.
- FSM states: RUN, CAPTURE, EDIT_SEC, EDIT_MIN, COMMIT.
- RUN:
  - btn[0] -> CAPTURE.
  - Other buttons are ignored.
  - set_mode = 0.
- CAPTURE:
  - Lasts exactly 1 cycle.
  - set_load_en = 1, set_mode = 1.
  - All buttons are ignored.
  - Unconditional -> EDIT_SEC.
- EDIT_SEC / EDIT_MIN:
  - set_mode = 1.
  - Priority when several buttons pulse in the same cycle: btn[3] > btn[0] > btn[1] > btn[2].
  - btn[3] -> RUN. No cur_load_en; edit discarded.
  - btn[0] -> COMMIT.
  - btn[1] toggles EDIT_SEC <-> EDIT_MIN.
  - btn[2] pulses inc_sec (EDIT_SEC) or inc_min (EDIT_MIN); the state is unchanged.
  - A lower-priority button that is not serviced is dropped.
- Increment wrap: the counters wrap 59 -> 00. The controller never carries a seconds wrap into minutes in set mode.
- COMMIT:
  - Lasts exactly 1 cycle.
  - cur_load_en = 1, set_mode = 1 (the mux still presents set_time during the load).
  - Buttons are ignored.
  - Unconditional -> RUN.
- Blink phase:
  - The phase counter counts clk_msec ticks only while in EDIT_*.
  - At terminal count BLINK_MS-1 the phase toggles and the counter clears.
  - The counter and phase clear on entering CAPTURE.
  - The counter and phase clear on a field toggle, so the new field starts visible.
- blink_mask:
  - EDIT_SEC: {2'b00, phase, phase}.
  - EDIT_MIN: {phase, phase, 2'b00}.
  - All other states: 0000.
- btn[2] in EDIT_* forces phase = 0 for that cycle. The digit stays visible while incrementing.
- clk_sec arriving in RUN is not this block's concern; the datapath handles it. inc_* are never asserted outside EDIT_*.
- Reset mid-edit: returns to RUN immediately. No load strobe is issued; cur_time is untouched.

Optional Feature:
- Macro: WATCH_SET_TIMEOUT_EN.
- With the macro defined:
  - An inactivity counter, $clog2(TIMEOUT_SEC+1) bits wide, counts clk_sec ticks in EDIT_*.
  - The counter clears on any btn_pedge pulse and on entering CAPTURE.
  - When it reaches TIMEOUT_SEC, the FSM goes to RUN without cur_load_en and timeout_pulse = 1 for 1 cycle.
  - A button pulse in the same cycle as the terminal tick wins: the counter clears and the button is serviced.
- Without the macro: no counter is built, timeout_pulse is tied 0, and edit mode persists indefinitely.

Decomposition:
- Package watch_ctrl_pkg:
  - State encoding localparams ST_RUN, ST_CAPTURE, ST_EDIT_SEC, ST_EDIT_MIN, ST_COMMIT (3-bit).
  - Button index constants BTN_ENTER=0, BTN_SEL=1, BTN_INC=2, BTN_CANCEL=3.
  - blink_mask digit ordering.
- Sub-module blink_gen:
  - Parameter BLINK_MS.
  - Inputs: clk, reset_p, enable, clear, tick.
  - Output: phase.
  - Instantiated once.

Test Plan:
- Reset, then btn[0] pulse -> set_load_en high exactly 1 cycle, 1 cycle later; set_mode=1; state EDIT_SEC.
- In EDIT_SEC: 3x btn[2] -> exactly 3 single-cycle inc_sec pulses, 0 inc_min. Then btn[1], 2x btn[2] -> 2 inc_min pulses.
- Commit path: btn[0] in EDIT_MIN -> cur_load_en 1 cycle with set_mode=1 in that cycle; set_mode=0 the next cycle.
- Cancel with simultaneous btn[0]|btn[3] in EDIT_SEC -> return to RUN; cur_load_en never asserted.
- Blink, BLINK_MS=4, clk_msec every cycle, EDIT_SEC -> blink_mask toggles 0000/0011 every 4 cycles. After btn[1] -> 0000 first, then 1100 phase.
- With WATCH_SET_TIMEOUT_EN and TIMEOUT_SEC=3: 3 clk_sec ticks with no buttons -> timeout_pulse 1 cycle, RUN, no cur_load_en. A btn[2] at tick 2 restarts the count.

Source files
------------

// File: rtl/watch_ctrl_pkg.sv
// Shared encodings for the watch set-mode controller: FSM states, button bit
// indices and blink_mask digit ordering {min10,min1,sec10,sec1}.
package watch_ctrl_pkg;

    typedef logic [2:0] state_t;

    localparam state_t ST_RUN      = 3'd0;
    localparam state_t ST_CAPTURE  = 3'd1;
    localparam state_t ST_EDIT_SEC = 3'd2;
    localparam state_t ST_EDIT_MIN = 3'd3;
    localparam state_t ST_COMMIT   = 3'd4;

    localparam int BTN_ENTER  = 0;
    localparam int BTN_SEL    = 1;
    localparam int BTN_INC    = 2;
    localparam int BTN_CANCEL = 3;

    localparam int DIG_SEC1  = 0;
    localparam int DIG_SEC10 = 1;
    localparam int DIG_MIN1  = 2;
    localparam int DIG_MIN10 = 3;

    // Blank both digits of the field being edited while the blink phase is high.
    function automatic logic [3:0] field_mask(input logic is_min, input logic phase);
        logic [3:0] m;
        m = 4'b0000;
        if (is_min) begin
            m[DIG_MIN10] = phase;
            m[DIG_MIN1]  = phase;
        end else begin
            m[DIG_SEC10] = phase;
            m[DIG_SEC1]  = phase;
        end
        return m;
    endfunction

endpackage

// File: rtl/blink_gen.sv
// Blink phase generator: toggles phase every BLINK_MS enabled ticks.
// clear has priority and restarts the half-period with phase low.
module blink_gen #(
    parameter int BLINK_MS = 500
) (
    input  logic clk,
    input  logic reset_p,
    input  logic enable,
    input  logic clear,
    input  logic tick,
    output logic phase
);

    localparam int CW = (BLINK_MS > 1) ? $clog2(BLINK_MS) : 1;

    logic [CW-1:0] cnt;

    always_ff @(posedge clk or posedge reset_p) begin
        if (reset_p) begin
            cnt   <= '0;
            phase <= 1'b0;
        end else if (clear) begin
            cnt   <= '0;
            phase <= 1'b0;
        end else if (enable && tick) begin
            if (cnt == CW'(BLINK_MS - 1)) begin
                cnt   <= '0;
                phase <= ~phase;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/watch_set_ctrl.sv
// Set-mode sequencer for the mm:ss watch: capture/edit/commit/cancel FSM with
// registered strobes. Optional inactivity abort under WATCH_SET_TIMEOUT_EN.
module watch_set_ctrl
    import watch_ctrl_pkg::*;
#(
    parameter int BLINK_MS    = 500,
    parameter int TIMEOUT_SEC = 30
) (
    input  logic       clk,
    input  logic       reset_p,
    input  logic [3:0] btn_pedge,
    input  logic       clk_msec,
    input  logic       clk_sec,
    output logic       set_mode,
    output logic       set_load_en,
    output logic       cur_load_en,
    output logic       inc_sec,
    output logic       inc_min,
    output logic [3:0] blink_mask,
    output logic       timeout_pulse
);

    state_t state;
    state_t state_nx;
    logic   in_edit;
    logic   do_inc;
    logic   do_sel;
    logic   do_abort;
    logic   to_hit;
    logic   blink_clr;
    logic   phase;
    logic   phase_eff;

    assign in_edit = (state == ST_EDIT_SEC) || (state == ST_EDIT_MIN);

`ifdef WATCH_SET_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_SEC + 1);

    logic [TW-1:0] to_cnt;

    // Any button pulse on the terminal tick keeps the edit alive.
    assign to_hit = in_edit && clk_sec && (btn_pedge == 4'b0000)
                 && (to_cnt == TW'(TIMEOUT_SEC - 1));

    always_ff @(posedge clk or posedge reset_p) begin
        if (reset_p) begin
            to_cnt <= '0;
        end else if (!in_edit || (|btn_pedge) || to_hit) begin
            to_cnt <= '0;
        end else if (clk_sec) begin
            to_cnt <= to_cnt + 1'b1;
        end
    end
`else
    logic unused_cfg;
    assign unused_cfg = clk_sec ^ (TIMEOUT_SEC > 0);
    assign to_hit     = 1'b0;
`endif

    always_comb begin
        state_nx = state;
        do_inc   = 1'b0;
        do_sel   = 1'b0;
        do_abort = 1'b0;
        case (state)
            ST_RUN: begin
                if (btn_pedge[BTN_ENTER]) state_nx = ST_CAPTURE;
            end
            ST_CAPTURE: state_nx = ST_EDIT_SEC;
            ST_EDIT_SEC, ST_EDIT_MIN: begin
                if (btn_pedge[BTN_CANCEL]) begin
                    state_nx = ST_RUN;
                end else if (btn_pedge[BTN_ENTER]) begin
                    state_nx = ST_COMMIT;
                end else if (btn_pedge[BTN_SEL]) begin
                    do_sel   = 1'b1;
                    state_nx = (state == ST_EDIT_SEC) ? ST_EDIT_MIN : ST_EDIT_SEC;
                end else if (btn_pedge[BTN_INC]) begin
                    do_inc = 1'b1;
                end else if (to_hit) begin
                    do_abort = 1'b1;
                    state_nx = ST_RUN;
                end
            end
            ST_COMMIT: state_nx = ST_RUN;
            default:   state_nx = ST_RUN;
        endcase
    end

    // New field (or fresh edit) starts with its digits visible.
    assign blink_clr = ((state == ST_RUN) && btn_pedge[BTN_ENTER]) || do_sel;
    assign phase_eff = phase && !do_inc && !blink_clr;

    blink_gen #(
        .BLINK_MS (BLINK_MS)
    ) u_blink (
        .clk     (clk),
        .reset_p (reset_p),
        .enable  (in_edit),
        .clear   (blink_clr),
        .tick    (clk_msec),
        .phase   (phase)
    );

    always_ff @(posedge clk or posedge reset_p) begin
        if (reset_p) begin
            state <= ST_RUN;
        end else begin
            state <= state_nx;
        end
    end

    always_ff @(posedge clk or posedge reset_p) begin
        if (reset_p) begin
            set_mode      <= 1'b0;
            set_load_en   <= 1'b0;
            cur_load_en   <= 1'b0;
            inc_sec       <= 1'b0;
            inc_min       <= 1'b0;
            blink_mask    <= 4'b0000;
            timeout_pulse <= 1'b0;
        end else begin
            set_mode      <= (state_nx != ST_RUN);
            set_load_en   <= (state_nx == ST_CAPTURE);
            cur_load_en   <= (state_nx == ST_COMMIT);
            inc_sec       <= do_inc && (state == ST_EDIT_SEC);
            inc_min       <= do_inc && (state == ST_EDIT_MIN);
            timeout_pulse <= do_abort;
            if (state_nx == ST_EDIT_SEC) begin
                blink_mask <= field_mask(1'b0, phase_eff);
            end else if (state_nx == ST_EDIT_MIN) begin
                blink_mask <= field_mask(1'b1, phase_eff);
            end else begin
                blink_mask <= 4'b0000;
            end
        end
    end

endmodule
